logic_unit_arbiter: RTL and testbench

Shares one bitwise logic unit (AND/OR/XOR/NAND over `BIT_WIDTH` bits) among `NUM_REQ` requesters using round-robin arbitration and a single-entry registered response stage. It sits between the LEG register-file read ports and the shared logic unit, so several issue slots can use one gate array. It accepts at most one request per cycle and presents one tagged result per cycle to a single consumer.

---
 rtl/leg_logic_pkg.sv | 5 +
 rtl/rr_picker.sv | 25 ++
 rtl/logic_unit_arbiter.sv | 59 +++++
 tb/tb_logic_unit_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/leg_logic_pkg.sv
// leg_logic_pkg: opcodes and response-stage state shared by LEG logic units
package leg_logic_pkg;
  localparam logic [1:0] OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11;
  typedef enum logic {EMPTY, FULL} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot round-robin pick searching upward from last+1
module rr_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one AND/OR/XOR/NAND unit with a registered response
module logic_unit_arbiter
  import leg_logic_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    BIT_WIDTH = 8,
  parameter int    NUM_REQ   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2:0]                   rsp_id,
  output logic [BIT_WIDTH-1:0]         rsp_data
);
  localparam int IW = $clog2(NUM_REQ);
  if (BIT_WIDTH < 1 || BIT_WIDTH > 64 || NUM_REQ < 2 || NUM_REQ > 8 || UUID < 0) begin : g_bad_cfg
    $error("%s: unsupported parameters", NAME);
  end
  arb_state_t state, state_n;
  logic [IW-1:0] last, g;
  logic [NUM_REQ-1:0] gnt;
  logic free, acc;
  logic [1:0] op;
  logic [BIT_WIDTH-1:0] a, b, res;
  rr_picker #(.N(NUM_REQ)) u_pick (.req(req_valid), .last(last), .gnt(gnt), .idx(g));
  always_comb begin
    free = state == EMPTY || rsp_ready;
    req_ready = (free && !rst) ? gnt : '0;
    acc = |req_ready;
    op = req_op[2*int'(g) +: 2];
    a = req_a[int'(g)*BIT_WIDTH +: BIT_WIDTH];
    b = req_b[int'(g)*BIT_WIDTH +: BIT_WIDTH];
    res = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : ~(a & b);
    state_n = acc ? FULL : rsp_ready ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      last <= IW'(NUM_REQ - 1);
      rsp_id <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        last <= g;
        rsp_id <= 3'(g);
        rsp_data <= res;
      end
    end
  end
  assign rsp_valid = state == FULL;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed and random checks against a behavioural arbiter model
module tb_logic_unit_arbiter;
  localparam int N = 4, BW = 8;
  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [N*BW-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready;
  logic [2:0] rsp_id;
  logic [BW-1:0] rsp_data;
  int n_chk = 0, n_fail = 0;
  bit m_full;
  int m_last, m_id;
  logic [BW-1:0] m_data;
  logic [N-1:0] m_gnt;
  logic [BW-1:0] held_data;
  logic [2:0] held_id;
  always #5 clk = ~clk;
  logic_unit_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [BW-1:0] op_fn(logic [1:0] op, logic [BW-1:0] a, logic [BW-1:0] b);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction
  task automatic set_req(int i, bit v, logic [1:0] op, logic [BW-1:0] a, logic [BW-1:0] b);
    req_valid[i] = v;
    req_op[2*i +: 2] = op;
    req_a[i*BW +: BW] = a;
    req_b[i*BW +: BW] = b;
  endtask
  task automatic step();
    int g = -1;
    #1;
    m_gnt = '0;
    if (!rst && (!m_full || rsp_ready))
      for (int k = 1; k <= N; k++) begin
        int j = (m_last + k) % N;
        if (req_valid[j] && g < 0) begin
          m_gnt[j] = 1'b1;
          g = j;
        end
      end
    chk("req_ready", 64'(req_ready), 64'(m_gnt));
    @(posedge clk);
    if (rst) begin
      m_full = 0;
      m_last = N - 1;
      m_id = 0;
      m_data = '0;
    end else if (g >= 0) begin
      m_full = 1;
      m_last = g;
      m_id = g;
      m_data = op_fn(req_op[2*g +: 2], req_a[g*BW +: BW], req_b[g*BW +: BW]);
    end else if (rsp_ready) m_full = 0;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_data", 64'(rsp_data), 64'(m_data));
  endtask
  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int acc_cnt;
    bit got1;
    rst = 1; rsp_ready = 1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    m_full = 0; m_last = N - 1; m_id = 0; m_data = '0;
    set_req(2, 1, 2'd0, 8'hFF, 8'hFF);
    step();
    step();
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    rst = 0;
    req_valid = '0;
    set_req(0, 1, 2'd0, 8'hF0, 8'h3C);
    step();
    chk("single_data", 64'(rsp_data), 64'h30);
    chk("single_id", 64'(rsp_id), 64'd0);
    rst = 1; step(); rst = 0;
    set_req(0, 1, 2'd0, 8'hF0, 8'h3C);
    set_req(1, 1, 2'd1, 8'hF0, 8'h0F);
    set_req(2, 1, 2'd2, 8'hAA, 8'hFF);
    set_req(3, 1, 2'd3, 8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_order", 64'(rsp_id), 64'(order[i]));
      chk("rr_data", 64'(rsp_data), i % 4 == 0 ? 64'h30 : i == 1 ? 64'hFF : i == 2 ? 64'h55 : 64'h00);
    end
    held_data = rsp_data;
    held_id = rsp_id;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", 64'(rsp_data), 64'(held_data));
      chk("bp_hold_id", 64'(rsp_id), 64'(held_id));
      chk("bp_no_grant", 64'(req_ready), 64'd0);
    end
    req_valid = 4'b0100;
    rsp_ready = 1;
    step();
    chk("bp_resume_id", 64'(rsp_id), 64'd2);
    chk("bp_resume_data", 64'(rsp_data), 64'h55);
    acc_cnt = 0;
    got1 = 0;
    for (int c = 0; c < 8 && !got1; c++) begin
      req_valid = {c[0], 1'b0, 1'b1, c[0]};
      step();
      if (m_gnt != '0) acc_cnt++;
      if (rsp_id == 3'd1 && rsp_valid) got1 = 1;
    end
    chk("fairness", 64'(got1 && acc_cnt <= N), 64'd1);
    req_valid = 4'b1111;
    rsp_ready = 0;
    step();
    chk("pre_reset_full", 64'(rsp_valid), 64'd1);
    rst = 1;
    step();
    chk("mid_reset_valid", 64'(rsp_valid), 64'd0);
    chk("mid_reset_id", 64'(rsp_id), 64'd0);
    rst = 0;
    rsp_ready = 1;
    req_valid = 4'b1001;
    step();
    chk("post_reset_first", 64'(rsp_id), 64'd0);
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 63) == 0;
      rsp_ready = $urandom_range(0, 9) < 7;
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 1) == 1, 2'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
